// File: rtl/dma_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dma_pkg : constants and state encoding shared by the descriptor path
// rev 1.0
// ---------------------------------------------------------------------------
package dma_pkg;

  localparam int DESCP_DWORDS = 4;
  localparam int DWORD_BYTES  = 4;

  // Bit positions inside descp_dword2, shared with the fetch engine
  localparam int VALID_BIT = 1;
  localparam int LINK_BIT  = 0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACK     = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    DONE    = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/descriptor_read_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// descriptor_read_responder : serves descriptor fetches with dword memory reads
// rev 1.0
// ---------------------------------------------------------------------------
module descriptor_read_responder
  import dma_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_DWORDS = 4
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              fetch_descp,
  input  logic [ADDR_W-1:0] addr_descp,
  input  logic [7:0]        length_descp,
  output logic              ack_fetch_descp,
  output logic              descpdata_valid,
  output logic [DATA_W-1:0] descp_dword0,
  output logic [DATA_W-1:0] descp_dword1,
  output logic [DATA_W-1:0] descp_dword2,
  output logic [DATA_W-1:0] descp_dword3,
  output logic              descp_rd_err,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_gnt,
  input  logic              mem_rd_data_valid,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_rd_err
);

  localparam int IDX_W = $clog2(DESCP_DWORDS);

  state_t             state;
  state_t             state_next;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   idx_inc;
  logic [IDX_W-1:0]   count_m1;
  logic [IDX_W-1:0]   len_last;
  logic [ADDR_W-3:0]  base;
  logic [DATA_W-1:0]  dword_q [DESCP_DWORDS];
  logic               rd_err_q;
  logic               req_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               unused_addr_lsbs;

  // Low address bits are dropped: reads are always dword aligned
  assign unused_addr_lsbs = ^addr_descp[1:0];
  assign idx_inc          = idx + IDX_W'(1);

  // Zero length or an oversized request fetches the full descriptor
  always_comb begin
    len_last = IDX_W'(MAX_DWORDS - 1);
    if (length_descp != 8'd0 && length_descp <= 8'(MAX_DWORDS))
      len_last = IDX_W'(length_descp - 8'd1);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fetch_descp) state_next = ACK;
      ACK:     state_next = RD_REQ;
      RD_REQ:  if (mem_rd_gnt) state_next = RD_WAIT;
      RD_WAIT: if (mem_rd_data_valid) state_next = (idx == count_m1) ? DONE : RD_REQ;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      idx      <= '0;
      count_m1 <= '0;
      base     <= '0;
      rd_err_q <= 1'b0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      for (int i = 0; i < DESCP_DWORDS; i++) dword_q[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fetch_descp) begin
            base     <= addr_descp[ADDR_W-1:2];
            count_m1 <= len_last;
          end
        end
        ACK: begin
          idx    <= '0;
          addr_q <= {base, 2'b00};
          for (int i = 0; i < DESCP_DWORDS; i++) dword_q[i] <= '0;
        end
        RD_WAIT: begin
          if (mem_rd_data_valid) begin
            // An errored beat leaves a zero word so dword2's valid bit reads clear
            dword_q[idx] <= mem_rd_err ? '0 : mem_rd_data;
            if (mem_rd_err) rd_err_q <= 1'b1;
            if (idx != count_m1) begin
              idx    <= idx_inc;
              addr_q <= {base + (ADDR_W-2)'(idx_inc), 2'b00};
            end
          end
        end
        DONE:    idx <= '0;
        default: ;
      endcase
      req_q <= (state_next == RD_REQ);
    end
  end

  assign ack_fetch_descp = (state == ACK);
  assign descpdata_valid = (state == DONE);
  assign descp_rd_err    = rd_err_q;
  assign mem_rd_req      = req_q;
  assign mem_rd_addr     = addr_q;
  assign descp_dword0    = dword_q[0];
  assign descp_dword1    = dword_q[1];
  assign descp_dword2    = dword_q[2];
  assign descp_dword3    = dword_q[3];

endmodule
`default_nettype wire

// File: tb/tb_descriptor_read_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_descriptor_read_responder : directed scoreboard bench for the responder
// rev 1.0
// ---------------------------------------------------------------------------
module tb_descriptor_read_responder;

  logic        clk = 1'b0;
  logic        rstb;
  logic        fetch_descp;
  logic [31:0] addr_descp;
  logic [7:0]  length_descp;
  logic        ack_fetch_descp;
  logic        descpdata_valid;
  logic [31:0] descp_dword0, descp_dword1, descp_dword2, descp_dword3;
  logic        descp_rd_err;
  logic        mem_rd_req;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_gnt;
  logic        mem_rd_data_valid;
  logic [31:0] mem_rd_data;
  logic        mem_rd_err;

  always #5 clk = ~clk;

  descriptor_read_responder dut (
    .clk               (clk),
    .rstb              (rstb),
    .fetch_descp       (fetch_descp),
    .addr_descp        (addr_descp),
    .length_descp      (length_descp),
    .ack_fetch_descp   (ack_fetch_descp),
    .descpdata_valid   (descpdata_valid),
    .descp_dword0      (descp_dword0),
    .descp_dword1      (descp_dword1),
    .descp_dword2      (descp_dword2),
    .descp_dword3      (descp_dword3),
    .descp_rd_err      (descp_rd_err),
    .mem_rd_req        (mem_rd_req),
    .mem_rd_addr       (mem_rd_addr),
    .mem_rd_gnt        (mem_rd_gnt),
    .mem_rd_data_valid (mem_rd_data_valid),
    .mem_rd_data       (mem_rd_data),
    .mem_rd_err        (mem_rd_err)
  );

  int           checks = 0;
  int           errors = 0;
  logic [31:0]  exp_addr_q [$];
  logic [127:0] exp_descp_q [$];
  logic         exp_rd_err = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hA5C3_0000 ^ {a[7:0], 24'h000011};
  endfunction

  function automatic int read_count(input logic [7:0] len);
    return (len == 8'd0 || len > 8'd4) ? 4 : int'(len);
  endfunction

  // Push the expected reads and descriptor, then drive the request through ack
  task automatic start_fetch(input logic [31:0] a, input logic [7:0] len, input int err_idx);
    logic [31:0]  b;
    logic [127:0] d;
    logic [31:0]  ai;
    b = {a[31:2], 2'b00};
    d = '0;
    for (int i = 0; i < read_count(len); i++) begin
      ai = b + 32'(4 * i);
      exp_addr_q.push_back(ai);
      if (i != err_idx) d[32*i +: 32] = mem_data(ai);
    end
    exp_descp_q.push_back(d);
    fetch_descp  = 1'b1;
    addr_descp   = a;
    length_descp = len;
    tick();
    check("ack_latency", ack_fetch_descp, 1'b1);
    fetch_descp  = 1'b0;
    addr_descp   = 32'hFFFF_FFFF;
    length_descp = 8'd1;
    tick();
    check("ack_pulse", ack_fetch_descp, 1'b0);
    check("req_latency", mem_rd_req, 1'b1);
    check("dwords_cleared", {descp_dword3, descp_dword2, descp_dword1, descp_dword0}, 128'd0);
  endtask

  task automatic serve_word(input int delay, input logic err);
    int          cnt;
    logic [31:0] a;
    cnt = 0;
    while (mem_rd_req !== 1'b1 && cnt < 50) begin
      tick();
      cnt++;
    end
    check("req_seen", mem_rd_req, 1'b1);
    a = mem_rd_addr;
    if (exp_addr_q.size() > 0) check("rd_addr", a, exp_addr_q.pop_front());
    else check("extra_read", exp_addr_q.size(), 1);
    for (int k = 0; k < delay; k++) begin
      tick();
      check("req_hold", {mem_rd_req, mem_rd_addr}, {1'b1, a});
    end
    mem_rd_gnt = 1'b1;
    tick();
    mem_rd_gnt = 1'b0;
    check("req_drop", mem_rd_req, 1'b0);
    tick();
    mem_rd_data_valid = 1'b1;
    mem_rd_err        = err;
    mem_rd_data       = err ? 32'hBAD0_BAD0 : mem_data(a);
    tick();
    mem_rd_data_valid = 1'b0;
    mem_rd_err        = 1'b0;
    mem_rd_data       = '0;
    if (err) exp_rd_err = 1'b1;
  endtask

  task automatic finish_fetch();
    int           cnt;
    logic [127:0] d;
    cnt = 0;
    while (descpdata_valid !== 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
    check("valid_latency", cnt, 0);
    check("valid", descpdata_valid, 1'b1);
    d = (exp_descp_q.size() > 0) ? exp_descp_q.pop_front() : 'x;
    check("descp", {descp_dword3, descp_dword2, descp_dword1, descp_dword0}, d);
    check("rd_err", descp_rd_err, exp_rd_err);
    tick();
    check("valid_pulse", descpdata_valid, 1'b0);
    check("no_extra_req", mem_rd_req, 1'b0);
    tick();
    tick();
    check("descp_hold", {descp_dword3, descp_dword2, descp_dword1, descp_dword0}, d);
  endtask

  task automatic run_fetch(input logic [31:0] a, input logic [7:0] len,
                           input int delay1, input int err_idx);
    start_fetch(a, len, err_idx);
    for (int i = 0; i < read_count(len); i++)
      serve_word((i == 1) ? delay1 : 0, i == err_idx);
    finish_fetch();
  endtask

  initial begin
    int c;
    rstb              = 1'b0;
    fetch_descp       = 1'b0;
    addr_descp        = '0;
    length_descp      = '0;
    mem_rd_gnt        = 1'b0;
    mem_rd_data_valid = 1'b0;
    mem_rd_data       = '0;
    mem_rd_err        = 1'b0;
    tick();
    tick();
    check("reset_outputs",
          {ack_fetch_descp, descpdata_valid, descp_rd_err, mem_rd_req, mem_rd_addr,
           descp_dword3, descp_dword2, descp_dword1, descp_dword0}, '0);
    rstb = 1'b1;
    tick();

    // Reset while waiting on the third read, then a stale data beat arrives
    start_fetch(32'h0000_3000, 8'd4, -1);
    serve_word(0, 1'b0);
    serve_word(0, 1'b0);
    c = 0;
    while (mem_rd_req !== 1'b1 && c < 50) begin
      tick();
      c++;
    end
    check("rst_rd_addr", mem_rd_addr, 32'h0000_3008);
    mem_rd_gnt = 1'b1;
    tick();
    mem_rd_gnt = 1'b0;
    rstb = 1'b0;
    #1;
    check("rst_async", {descp_dword1, descp_dword0, mem_rd_req}, '0);
    tick();
    rstb = 1'b1;
    tick();
    mem_rd_data_valid = 1'b1;
    mem_rd_data       = 32'h1234_5678;
    tick();
    mem_rd_data_valid = 1'b0;
    check("rst_late_data",
          {ack_fetch_descp, descpdata_valid, descp_rd_err, mem_rd_req, mem_rd_addr,
           descp_dword3, descp_dword2, descp_dword1, descp_dword0}, '0);
    tick();
    check("rst_no_valid", descpdata_valid, 1'b0);
    exp_addr_q.delete();
    exp_descp_q.delete();

    run_fetch(32'h0000_1000, 8'd4, 0, -1);
    run_fetch(32'h0000_2003, 8'd2, 0, -1);
    run_fetch(32'h0000_2000, 8'd0, 0, -1);
    run_fetch(32'h0000_4000, 8'd9, 0, -1);
    run_fetch(32'h0000_1000, 8'd4, 5, -1);
    run_fetch(32'h0000_5000, 8'd4, 0, 2);
    run_fetch(32'h0000_5000, 8'd4, 0, -1);
    run_fetch(32'hFFFF_FFF8, 8'd4, 0, -1);
    run_fetch(32'h0000_6004, 8'd3, 2, -1);

    check("scoreboard_empty", exp_addr_q.size() + exp_descp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
